// File: rtl/irq_ctrl.sv
// irq_ctrl: eight-source programmable interrupt controller.
// Each source is synchronised and edge-detected, then latched in PEND.
// The lowest-index source set in both PEND and MASK wins arbitration.
// The winner is delivered to the core as an irq_o pulse of PULSE_LEN cycles.
// Service ends when the core writes EOI, followed by a one-cycle low gap.
module irq_ctrl #(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_LEN   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [7:0]         io_addr_i,
    input  logic [7:0]         io_data_i,
    input  logic               io_we_i,
    output logic [7:0]         io_data_o,
    output logic               irq_o
);

    localparam logic [7:0] ADDR_PEND = BASE_ADDR;
    localparam logic [7:0] ADDR_MASK = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_VEC  = BASE_ADDR + 8'd2;
    localparam logic [7:0] ADDR_EOI  = BASE_ADDR + 8'd3;
    localparam logic [7:0] ADDR_STAT = BASE_ADDR + 8'd4;

    localparam int unsigned CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        WAIT_EOI,
        GAP
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_n;
    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] win_oh;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] grant_clr;
    logic [2:0]         win_id;
    logic [2:0]         active_id;
    logic               grant;
    logic               release_svc;
    logic               busy;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_eoi;

    assign wr_pend = io_we_i && (io_addr_i == ADDR_PEND);
    assign wr_mask = io_we_i && (io_addr_i == ADDR_MASK);
    assign wr_eoi  = io_we_i && (io_addr_i == ADDR_EOI);

    assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign req       = pend_q & mask_q;
    assign busy      = (state_q == ASSERT) || (state_q == WAIT_EOI);
    assign w1c       = wr_pend ? io_data_i[NUM_SRC-1:0] : '0;
    assign grant_clr = grant ? win_oh : '0;

    // Synchroniser chain and edge-detect history per source.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= src_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Pending and mask registers; a new edge overrides any clear on the same bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= (pend_q & ~(w1c | grant_clr)) | rise;
            if (wr_mask) begin
                mask_q <= io_data_i[NUM_SRC-1:0];
            end
        end
    end

    // Fixed-priority arbiter: the lowest set index wins.
    always_comb begin
        win_id = '0;
        win_oh = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (req[i-1]) begin
                win_id      = 3'(i - 1);
                win_oh      = '0;
                win_oh[i-1] = 1'b1;
            end
        end
    end

    // Delivery FSM state, pulse counter, in-service id and registered irq_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            active_id <= '0;
            irq_o     <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            irq_o   <= (state_n == ASSERT);
            if (grant) begin
                active_id <= win_id;
            end else if (release_svc) begin
                active_id <= '0;
            end
        end
    end

    // Next-state logic; an EOI during ASSERT cuts the pulse short and skips WAIT_EOI.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        grant       = 1'b0;
        release_svc = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_n = ASSERT;
                    cnt_n   = '0;
                    grant   = 1'b1;
                end
            end
            ASSERT: begin
                if (wr_eoi) begin
                    state_n     = GAP;
                    release_svc = 1'b1;
                end else if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
                    state_n = WAIT_EOI;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            WAIT_EOI: begin
                if (wr_eoi) begin
                    state_n     = GAP;
                    release_svc = 1'b1;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Combinational register read-back; unused bits and unmapped addresses read zero.
    always_comb begin
        io_data_o = '0;
        case (io_addr_i)
            ADDR_PEND: io_data_o = 8'(pend_q);
            ADDR_MASK: io_data_o = 8'(mask_q);
            ADDR_VEC:  io_data_o = busy ? {1'b1, 4'b0, active_id} : 8'h00;
            ADDR_STAT: io_data_o = {6'b0, busy, irq_o};
            default:   io_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl with hand-computed expected values.
module tb_irq_ctrl;

    localparam logic [7:0] A_PEND = 8'hF0;
    localparam logic [7:0] A_MASK = 8'hF1;
    localparam logic [7:0] A_VEC  = 8'hF2;
    localparam logic [7:0] A_EOI  = 8'hF3;
    localparam logic [7:0] A_STAT = 8'hF4;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic [7:0] io_addr;
    logic [7:0] io_wdata;
    logic       io_we;
    logic [7:0] io_rdata;
    logic       irq;

    int n_checks;
    int n_fail;

    irq_ctrl #(
        .BASE_ADDR   (8'hF0),
        .NUM_SRC     (8),
        .SYNC_STAGES (2),
        .PULSE_LEN   (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .src_i     (src),
        .io_addr_i (io_addr),
        .io_data_i (io_wdata),
        .io_we_i   (io_we),
        .io_data_o (io_rdata),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_addr  = a;
        io_wdata = d;
        io_we    = 1'b1;
        tick();
        io_we    = 1'b0;
    endtask

    task automatic rdchk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        io_addr = a;
        #1;
        check(tag, io_rdata, exp);
    endtask

    task automatic irqchk(input string tag, input logic exp);
        check(tag, {7'b0, irq}, {7'b0, exp});
    endtask

    // Raise the given sources for one cycle.
    task automatic pulse(input logic [7:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        src      = '0;
        io_addr  = '0;
        io_wdata = '0;
        io_we    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        irqchk("rst_irq", 1'b0);
        rdchk("rst_pend", A_PEND, 8'h00);
        rdchk("rst_mask", A_MASK, 8'h00);
        rdchk("rst_vec",  A_VEC,  8'h00);
        rdchk("rst_stat", A_STAT, 8'h00);
        rdchk("unmapped", 8'h10,  8'h00);

        // Single source 0 delivery
        wr(A_MASK, 8'h01);
        pulse(8'h01);
        tick();
        rdchk("t1_pend_early", A_PEND, 8'h00);
        tick();
        rdchk("t1_pend_set", A_PEND, 8'h01);
        irqchk("t1_irq_pre", 1'b0);
        tick();
        irqchk("t1_irq_c1", 1'b1);
        rdchk("t1_vec", A_VEC, 8'h80);
        rdchk("t1_pend_clr", A_PEND, 8'h00);
        rdchk("t1_stat_assert", A_STAT, 8'h03);
        tick();
        irqchk("t1_irq_c2", 1'b1);
        tick();
        irqchk("t1_irq_end", 1'b0);
        rdchk("t1_stat_wait", A_STAT, 8'h02);
        rdchk("t1_vec_wait", A_VEC, 8'h80);
        wr(A_EOI, 8'h5A);
        rdchk("t1_vec_eoi", A_VEC, 8'h00);
        rdchk("t1_stat_eoi", A_STAT, 8'h00);
        tick();

        // Simultaneous sources 5 and 2
        wr(A_MASK, 8'hFF);
        rdchk("t2_mask", A_MASK, 8'hFF);
        pulse(8'h24);
        tick();
        tick();
        rdchk("t2_pend", A_PEND, 8'h24);
        tick();
        irqchk("t2_irq_a", 1'b1);
        rdchk("t2_vec_a", A_VEC, 8'h82);
        rdchk("t2_pend_a", A_PEND, 8'h20);
        tick();
        tick();
        irqchk("t2_irq_wait", 1'b0);
        wr(A_EOI, 8'h00);
        irqchk("t2_irq_gap", 1'b0);
        tick();
        irqchk("t2_irq_idle", 1'b0);
        tick();
        irqchk("t2_irq_b", 1'b1);
        rdchk("t2_vec_b", A_VEC, 8'h85);
        rdchk("t2_pend_b", A_PEND, 8'h00);
        tick();
        tick();
        wr(A_EOI, 8'h00);
        tick();

        // Masked source 3, W1C, then unmask
        wr(A_MASK, 8'h00);
        pulse(8'h08);
        tick();
        tick();
        rdchk("t3_pend", A_PEND, 8'h08);
        tick();
        irqchk("t3_irq_masked", 1'b0);
        wr(A_PEND, 8'h08);
        rdchk("t3_pend_w1c", A_PEND, 8'h00);
        wr(A_MASK, 8'h08);
        tick();
        irqchk("t3_no_delivery", 1'b0);
        wr(A_MASK, 8'h00);
        pulse(8'h08);
        tick();
        tick();
        rdchk("t3_pend2", A_PEND, 8'h08);
        wr(A_MASK, 8'h08);
        irqchk("t3_irq_same", 1'b0);
        tick();
        irqchk("t3_irq_rise", 1'b1);
        rdchk("t3_vec", A_VEC, 8'h83);
        tick();
        tick();
        irqchk("t3_irq_wait", 1'b0);

        // Two edges on source 1 while waiting for EOI
        wr(A_MASK, 8'hFF);
        pulse(8'h02);
        tick();
        pulse(8'h02);
        tick();
        tick();
        rdchk("t4_pend", A_PEND, 8'h02);
        rdchk("t4_vec_held", A_VEC, 8'h83);
        rdchk("t4_stat", A_STAT, 8'h02);
        wr(A_EOI, 8'h00);
        irqchk("t4_gap", 1'b0);
        tick();
        irqchk("t4_idle", 1'b0);
        tick();
        irqchk("t4_irq", 1'b1);
        rdchk("t4_vec", A_VEC, 8'h81);
        rdchk("t4_pend_clr", A_PEND, 8'h00);
        tick();
        tick();
        wr(A_EOI, 8'h00);
        repeat (3) tick();
        irqchk("t4_no_repeat", 1'b0);
        rdchk("t4_pend_final", A_PEND, 8'h00);

        // Same-cycle W1C and new edge on source 4
        wr(A_MASK, 8'h00);
        pulse(8'h10);
        tick();
        tick();
        rdchk("t5_pend_pre", A_PEND, 8'h10);
        src = 8'h10;
        tick();
        tick();
        wr(A_PEND, 8'h10);
        src = 8'h00;
        rdchk("t5_set_wins", A_PEND, 8'h10);

        // EOI in IDLE is ignored
        wr(A_EOI, 8'hFF);
        rdchk("t6_vec", A_VEC, 8'h00);
        rdchk("t6_stat", A_STAT, 8'h00);
        rdchk("t6_pend", A_PEND, 8'h10);
        pulse(8'h40);
        tick();
        tick();
        rdchk("t6_pend2", A_PEND, 8'h50);
        wr(A_MASK, 8'h50);
        tick();
        irqchk("t6_irq", 1'b1);
        rdchk("t6_vec_busy", A_VEC, 8'h84);
        rdchk("t6_pend_rest", A_PEND, 8'h40);

        // Reset during ASSERT
        rst = 1'b1;
        #1;
        irqchk("t7_irq_async", 1'b0);
        tick();
        rst = 1'b0;
        rdchk("t7_pend", A_PEND, 8'h00);
        rdchk("t7_mask", A_MASK, 8'h00);
        rdchk("t7_vec",  A_VEC,  8'h00);
        rdchk("t7_stat", A_STAT, 8'h00);

        // EOI during ASSERT truncates the pulse
        wr(A_MASK, 8'h01);
        pulse(8'h01);
        tick();
        tick();
        tick();
        irqchk("t8_irq", 1'b1);
        wr(A_EOI, 8'h00);
        irqchk("t8_irq_cut", 1'b0);
        rdchk("t8_vec", A_VEC, 8'h00);
        rdchk("t8_stat", A_STAT, 8'h00);
        tick();
        irqchk("t8_idle", 1'b0);
        tick();
        irqchk("t8_quiet", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
